simd_result_collector: RTL and testbench
========================================

SIMD_RESULT_COLLECTOR -- requirements
Module: simd_result_collector

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, meaning the number of buffered result vectors (power of two, at least 2).
REQ-002 The block SHALL have parameter ADDR_W, default 7, meaning the width of mem_addr.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  begins a job when the block is IDLE.
REQ-007 data_size  input  6  number of result vectors in the job; sampled on an accepted start.
REQ-008 in_valid  input  1  the SIMD lane outputs carry a valid result vector this cycle.
REQ-009 out_procc0..out_procc3  input  32 each  primary lane results.
REQ-010 out_extra_procc0..out_extra_procc3  input  32 each  extra lane results.
REQ-011 mem_valid  output  1  a memory write beat is presented.
REQ-012 mem_ready  input  1  the memory side accepts the beat.
REQ-013 mem_data  output  128  beat payload.
REQ-014 mem_sel  output  1  0 = primary beat, 1 = extra beat.
REQ-015 mem_addr  output  ADDR_W  beat address.
REQ-016 busy  output  1  high in COLLECT and DRAIN.
REQ-017 done  output  1  one-cycle pulse at job end.
REQ-018 overflow  output  1  sticky flag: a result vector was dropped in the current job.

Function
REQ-019 The FSM SHALL have the states IDLE, COLLECT, DRAIN and DONE.
REQ-020 In IDLE, start=1 SHALL latch data_size into expected, clear captured count, mem_addr and overflow, then enter COLLECT, or enter DONE directly if data_size=0.
REQ-021 start SHALL be ignored in every state other than IDLE.
REQ-022 In COLLECT, each in_valid=1 cycle SHALL increment the seen count by 1, whether the vector is stored or dropped.
REQ-023 A vector SHALL be pushed when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-024 Otherwise the vector SHALL be dropped and overflow set to 1.
REQ-025 Pushed entry packing: primary word = {out_procc3, out_procc2, out_procc1, out_procc0} with out_procc0 in [31:0]; extra word packed the same way from out_extra_procc3..0.
REQ-026 in_valid outside COLLECT SHALL be ignored: no push, no count change.
REQ-027 COLLECT SHALL go to DRAIN in the cycle after the seen count reaches expected.
REQ-028 DRAIN SHALL go to DONE when the FIFO is empty and no beat is outstanding.
REQ-029 DONE SHALL assert done=1 for exactly one cycle and then go to IDLE.
REQ-030 Output side: mem_valid SHALL be 1 whenever the FIFO is non-empty, in any state.
REQ-031 Each FIFO entry SHALL be emitted as two beats: the primary word with mem_sel=0, then the extra word with mem_sel=1.
REQ-032 A beat SHALL transfer on mem_valid && mem_ready.
REQ-033 The entry SHALL be popped on transfer of its extra beat.
REQ-034 mem_data, mem_sel and mem_addr SHALL stay stable while mem_valid=1 and mem_ready=0.
REQ-035 mem_addr SHALL increment by 1 per transferred beat and wrap modulo 2^ADDR_W.
REQ-036 Latency: a vector pushed at edge N SHALL present its primary beat with mem_valid=1 in the cycle following edge N, i.e. beats are driven from FIFO registers with no combinational path from in_valid.
REQ-037 Sustained throughput SHALL be one vector per 2 cycles with mem_ready=1; faster input fills the FIFO and then drops vectors.
REQ-038 overflow SHALL hold its value until the next accepted start or reset.

Reset
REQ-039 On reset=1 at a rising edge, the block SHALL enter IDLE, empty the FIFO and set the beat phase to primary.
REQ-040 On reset=1 at a rising edge, outputs SHALL be mem_valid=0, mem_sel=0, mem_data=0, mem_addr=0, busy=0, done=0, overflow=0.
REQ-041 Reset SHALL take priority over all other inputs, including reset asserted mid-job, where buffered entries are discarded.
REQ-042 No beat SHALL be presented in the cycle after reset.

Verification
REQ-043 start with data_size=2; two in_valid cycles with out_procc0..3=0x11111111/0x22222222/0x33333333/0x44444444 and extras 0x1..0x4; mem_ready=1 -> beats at addr 0..3: 0x44444444_33333333_22222222_11111111 (sel 0), 0x00000004_00000003_00000002_00000001 (sel 1), repeated for the second vector; then one done pulse; overflow=0.
REQ-044 mem_ready=0 throughout; start with data_size=13 and 13 consecutive in_valid cycles -> 8 vectors stored, 5 dropped, overflow=1. Raise mem_ready -> 16 beats at addr 0..15, mem_data stable while stalled, then done.
REQ-045 start with data_size=0 -> busy stays 0, done pulses in the second cycle after start, no beats.
REQ-046 Assert reset mid-DRAIN with 3 entries buffered -> the next cycle shows mem_valid=0, busy=0, mem_addr=0, and no done pulse.
REQ-047 start pulsed while busy, and in_valid pulsed in IDLE -> no effect on counts, addresses or beats.
REQ-048 FIFO full with mem_ready=1 and in_valid=1 in the cycle of an extra-beat pop -> the vector is pushed, and overflow stays 0.

Source files
------------

// File: rtl/simd_result_collector.sv
// simd_result_collector
//   Collects SIMD lane result vectors into a small FIFO and streams each
//   entry to memory as two 128-bit beats: the primary word, then the extra word.
//
// Ports
//   clk, reset              : clock, synchronous active-high reset
//   start, data_size        : job start (honoured only in IDLE) and job length in vectors
//   in_valid                : lane outputs carry a result vector this cycle
//   out_procc0..3           : primary lane results (lane 0 lands in bits [31:0])
//   out_extra_procc0..3     : extra lane results, packed the same way
//   mem_valid / mem_ready   : beat handshake
//   mem_data, mem_sel       : beat payload; sel 0 = primary, 1 = extra
//   mem_addr                : beat address, +1 per transferred beat
//   busy, done, overflow    : job status; done is a one-cycle pulse, overflow is sticky
module simd_result_collector #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_W     = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [5:0]        data_size,
    input  logic              in_valid,
    input  logic [31:0]       out_procc0,
    input  logic [31:0]       out_procc1,
    input  logic [31:0]       out_procc2,
    input  logic [31:0]       out_procc3,
    input  logic [31:0]       out_extra_procc0,
    input  logic [31:0]       out_extra_procc1,
    input  logic [31:0]       out_extra_procc2,
    input  logic [31:0]       out_extra_procc3,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [127:0]      mem_data,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StCollect, StDrain, StDone} state_e;

    state_e              state_q;
    logic [5:0]          expected_q;
    logic [5:0]          seen_q;
    logic                overflow_q;
    logic                done_q;

    // Each entry holds {extra word, primary word}.
    logic [255:0]        fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0]     wr_ptr_q;
    logic [PtrW-1:0]     rd_ptr_q;
    logic [PtrW:0]       count_q;
    logic                phase_q;   // 0: primary beat pending, 1: extra beat pending
    logic [ADDR_W-1:0]   addr_q;

    logic                fifo_empty;
    logic                fifo_full;
    logic                xfer;
    logic                pop;
    logic                accept_in;
    logic                push;
    logic                last_in;
    logic [255:0]        head;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (PtrW + 1)'(FIFO_DEPTH));
    assign xfer       = !fifo_empty && mem_ready;
    assign pop        = xfer && phase_q;
    assign accept_in  = (state_q == StCollect) && in_valid;
    // A full FIFO still takes the vector when its head leaves in the same cycle.
    assign push       = accept_in && (!fifo_full || pop);
    assign last_in    = (({1'b0, seen_q} + 7'd1) == {1'b0, expected_q});
    assign head       = fifo_q[rd_ptr_q];

    // Control FSM with registered status.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            expected_q <= '0;
            seen_q     <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state_q == StDone);
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        expected_q <= data_size;
                        seen_q     <= '0;
                        overflow_q <= 1'b0;
                        state_q    <= (data_size == '0) ? StDone : StCollect;
                    end
                end
                StCollect: begin
                    if (in_valid) begin
                        seen_q <= seen_q + 6'd1;
                        if (!push) begin
                            overflow_q <= 1'b1;
                        end
                        if (last_in) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (fifo_empty) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // FIFO storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {out_extra_procc3, out_extra_procc2,
                                 out_extra_procc1, out_extra_procc0,
                                 out_procc3, out_procc2, out_procc1, out_procc0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            phase_q  <= 1'b0;
            addr_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (xfer) begin
                phase_q <= ~phase_q;
            end
            // The FIFO is always empty in IDLE, so a start never races a beat.
            if ((state_q == StIdle) && start) begin
                addr_q <= '0;
            end else if (xfer) begin
                addr_q <= addr_q + 1'b1;
            end
        end
    end

    assign mem_valid = !fifo_empty;
    assign mem_data  = fifo_empty ? '0 : (phase_q ? head[255:128] : head[127:0]);
    assign mem_sel   = phase_q;
    assign mem_addr  = addr_q;
    assign busy      = (state_q == StCollect) || (state_q == StDrain);
    assign done      = done_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_simd_result_collector.sv
module tb_simd_result_collector;

    localparam int unsigned Depth = 8;
    localparam int unsigned AddrW = 7;

    localparam int MIdle    = 0;
    localparam int MCollect = 1;
    localparam int MDrain   = 2;
    localparam int MDone    = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [5:0]        data_size;
    logic              in_valid;
    logic [31:0]       p [4];
    logic [31:0]       e [4];
    logic              mem_valid;
    logic              mem_ready;
    logic [127:0]      mem_data;
    logic              mem_sel;
    logic [AddrW-1:0]  mem_addr;
    logic              busy;
    logic              done;
    logic              overflow;

    simd_result_collector #(
        .FIFO_DEPTH (Depth),
        .ADDR_W     (AddrW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .data_size        (data_size),
        .in_valid         (in_valid),
        .out_procc0       (p[0]),
        .out_procc1       (p[1]),
        .out_procc2       (p[2]),
        .out_procc3       (p[3]),
        .out_extra_procc0 (e[0]),
        .out_extra_procc1 (e[1]),
        .out_extra_procc2 (e[2]),
        .out_extra_procc3 (e[3]),
        .mem_valid        (mem_valid),
        .mem_ready        (mem_ready),
        .mem_data         (mem_data),
        .mem_sel          (mem_sel),
        .mem_addr         (mem_addr),
        .busy             (busy),
        .done             (done),
        .overflow         (overflow)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct packed {
        logic [127:0] ext;
        logic [127:0] prim;
    } ent_t;

    ent_t            mq[$];
    int              m_state = MIdle;
    bit              m_phase = 1'b0;
    logic [AddrW-1:0] m_addr = '0;
    int              m_seen = 0;
    int              m_exp = 0;
    bit              m_ovf = 1'b0;
    bit              m_done = 1'b0;
    int              old_state;
    int              old_size;
    bit              m_xfer;
    bit              m_pop;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_state = MIdle;
            m_phase = 1'b0;
            m_addr  = '0;
            m_seen  = 0;
            m_exp   = 0;
            m_ovf   = 1'b0;
            m_done  = 1'b0;
        end else begin
            old_state = m_state;
            old_size  = mq.size();
            m_xfer    = (old_size != 0) && mem_ready;
            m_pop     = m_xfer && m_phase;
            if (m_xfer) begin
                m_addr  = m_addr + 1'b1;
                m_phase = !m_phase;
            end
            if (m_pop) void'(mq.pop_front());
            case (old_state)
                MIdle: if (start) begin
                    m_exp   = int'(data_size);
                    m_seen  = 0;
                    m_ovf   = 1'b0;
                    m_addr  = '0;
                    m_state = (data_size == 0) ? MDone : MCollect;
                end
                MCollect: if (in_valid) begin
                    m_seen++;
                    if (mq.size() < Depth)
                        mq.push_back('{ext: {e[3], e[2], e[1], e[0]},
                                       prim: {p[3], p[2], p[1], p[0]}});
                    else
                        m_ovf = 1'b1;
                    if (m_seen == m_exp) m_state = MDrain;
                end
                MDrain: if (old_size == 0) m_state = MDone;
                default: m_state = MIdle;
            endcase
            m_done = (old_state == MDone);
        end
    end

    // Compare process: every output, every cycle, away from the clock edge.
    logic [127:0] exp_data;
    always @(negedge clk) begin
        if (chk_en) begin
            exp_data = '0;
            if (mq.size() != 0) exp_data = m_phase ? mq[0].ext : mq[0].prim;
            chk("mem_valid", mem_valid, mq.size() != 0);
            chk("mem_data", mem_data, exp_data);
            chk("mem_sel", mem_sel, m_phase);
            chk("mem_addr", mem_addr, m_addr);
            chk("busy", busy, (m_state == MCollect) || (m_state == MDrain));
            chk("done", done, m_done);
            chk("overflow", overflow, m_ovf);
        end
    end

    // Log of transferred beats, used by the directed literal checks.
    typedef struct {
        logic [127:0]     d;
        logic             s;
        logic [AddrW-1:0] a;
    } beat_t;
    beat_t log_q[$];
    int    done_cnt = 0;

    always @(negedge clk) begin
        if (!reset && mem_valid && mem_ready) log_q.push_back('{mem_data, mem_sel, mem_addr});
        if (done) done_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_lanes();
        for (int i = 0; i < 4; i++) begin
            p[i] = $urandom;
            e[i] = $urandom;
        end
    endtask

    task automatic wait_done(input int limit, input string name);
        int d0;
        bit seen;
        d0   = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            if (done_cnt != d0) seen = 1'b1;
        end
        chk({name, "_done_seen"}, seen, 1'b1);
    endtask

    task automatic start_job(input logic [5:0] ds);
        start     = 1'b1;
        data_size = ds;
        tick();
        start     = 1'b0;
    endtask

    logic [127:0] prim_lit;
    logic [127:0] ext_lit;
    int           d0;

    initial begin
        reset = 1'b1; start = 1'b0; data_size = '0; in_valid = 1'b0; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin p[i] = '0; e[i] = '0; end
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mem_valid", mem_valid, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_data", mem_data, '0);
        chk("rst_busy", busy, 1'b0);
        tick();

        // Two-vector job, literal beats.
        prim_lit  = 128'h44444444_33333333_22222222_11111111;
        ext_lit   = 128'h00000004_00000003_00000002_00000001;
        mem_ready = 1'b1;
        log_q.delete();
        d0 = done_cnt;
        start_job(6'd2);
        p[0] = 32'h11111111; p[1] = 32'h22222222; p[2] = 32'h33333333; p[3] = 32'h44444444;
        e[0] = 32'h1; e[1] = 32'h2; e[2] = 32'h3; e[3] = 32'h4;
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        wait_done(40, "t1");
        tick(); tick();
        chk("t1_nbeats", log_q.size(), 4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            chk("t1_data", log_q[i].d, (i % 2) ? ext_lit : prim_lit);
            chk("t1_sel", log_q[i].s, (i % 2) != 0);
            chk("t1_addr", log_q[i].a, i);
        end
        chk("t1_ndone", done_cnt - d0, 1);
        chk("t1_ovf", overflow, 1'b0);

        // 13 vectors into a stalled 8-entry FIFO.
        mem_ready = 1'b0;
        log_q.delete();
        start_job(6'd13);
        in_valid = 1'b1;
        for (int i = 0; i < 13; i++) begin rand_lanes(); tick(); end
        in_valid = 1'b0;
        tick(); tick(); tick();
        @(negedge clk);
        chk("t2_ovf", overflow, 1'b1);
        chk("t2_stalled_valid", mem_valid, 1'b1);
        chk("t2_no_beats", log_q.size(), 0);
        tick();
        mem_ready = 1'b1;
        wait_done(80, "t2");
        chk("t2_nbeats", log_q.size(), 16);
        for (int i = 0; i < log_q.size(); i++) chk("t2_addr", log_q[i].a, i);

        // Empty job: done two cycles after start, never busy.
        tick();
        log_q.delete();
        start_job(6'd0);
        @(negedge clk);
        chk("t3_done_early", done, 1'b0);
        chk("t3_busy0", busy, 1'b0);
        tick();
        @(negedge clk);
        chk("t3_done", done, 1'b1);
        chk("t3_busy1", busy, 1'b0);
        tick(); tick();
        chk("t3_nbeats", log_q.size(), 0);

        // Reset in DRAIN with three entries buffered.
        mem_ready = 1'b0;
        start_job(6'd4);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin rand_lanes(); tick(); end
        in_valid  = 1'b0;
        mem_ready = 1'b1;
        tick(); tick();
        mem_ready = 1'b0;
        @(negedge clk);
        chk("t4_pre_addr", mem_addr, 2);
        reset = 1'b1;
        d0    = done_cnt;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t4_valid", mem_valid, 1'b0);
        chk("t4_busy", busy, 1'b0);
        chk("t4_addr", mem_addr, 0);
        chk("t4_done", done, 1'b0);
        tick(); tick(); tick();
        chk("t4_ndone", done_cnt - d0, 0);

        // Stray in_valid in IDLE and start while busy are ignored.
        mem_ready = 1'b1;
        log_q.delete();
        in_valid  = 1'b1;
        rand_lanes();
        tick(); tick();
        in_valid = 1'b0;
        tick();
        chk("t5_idle_beats", log_q.size(), 0);
        start_job(6'd3);
        in_valid = 1'b1;
        rand_lanes();
        tick();
        start = 1'b1; data_size = 6'd40;
        rand_lanes();
        tick();
        start = 1'b0;
        rand_lanes();
        tick();
        in_valid = 1'b0;
        wait_done(40, "t5");
        chk("t5_nbeats", log_q.size(), 6);
        for (int i = 0; i < log_q.size(); i++) chk("t5_addr", log_q[i].a, i);

        // Full FIFO accepts a vector in the cycle of an extra-beat pop.
        tick();
        mem_ready = 1'b0;
        log_q.delete();
        start_job(6'd9);
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin rand_lanes(); tick(); end
        in_valid  = 1'b0;
        mem_ready = 1'b1;
        tick();
        in_valid = 1'b1;
        rand_lanes();
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t6_ovf", overflow, 1'b0);
        chk("t6_busy", busy, 1'b1);
        wait_done(60, "t6");
        chk("t6_nbeats", log_q.size(), 18);

        // Randomized traffic, model-checked every cycle.
        for (int c = 0; c < 4000; c++) begin
            reset     = ($urandom_range(0, 499) == 0);
            start     = ($urandom_range(0, 7) == 0);
            data_size = 6'($urandom_range(0, 20));
            in_valid  = $urandom_range(0, 1) != 0;
            mem_ready = ($urandom_range(0, 3) != 0);
            rand_lanes();
            tick();
        end
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 100; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
